// File: rtl/hcsr04_emulador.sv
// HC-SR04 responder: validates the trigger width, waits the burst time, then
// returns an echo pulse whose width encodes the programmed distance.
module hcsr04_emulador #(
  parameter int TRIG_MIN_CYC = 250,
  parameter int BURST_CYC    = 5000,
  parameter int CYC_PER_CM   = 1450,
  parameter int MIN_CM       = 2,
  parameter int MAX_CM       = 400,
  parameter int TIMEOUT_CYC  = 950000,
  parameter int HOLDOFF_CYC  = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger,
  input  logic [8:0] distancia_cm,
  input  logic       sin_objeto,
  output logic       echo,
  output logic       ocupado,
  output logic       trig_invalido,
  output logic       medida_hecha
);

  // state   | meaning
  // S_IDLE  | waiting for a fresh rising edge of the synchronized trigger
  // S_TRIG  | trigger high, measuring its width
  // S_BURST | simulated ultrasonic burst delay
  // S_ECHO  | echo high for the latched target width
  // S_HOLD  | dead time before another trigger is accepted
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_BURST, S_ECHO, S_HOLD} state_t;

  localparam logic [19:0] L_TRIG_MIN = 20'(TRIG_MIN_CYC);
  localparam logic [19:0] L_BURST_M1 = 20'(BURST_CYC - 1);
  localparam logic [19:0] L_CPC      = 20'(CYC_PER_CM);
  localparam logic [19:0] L_TIMEOUT  = 20'(TIMEOUT_CYC);
  localparam logic [19:0] L_HOLDOFF  = 20'(HOLDOFF_CYC);
  localparam logic [8:0]  L_MIN_CM   = 9'(MIN_CM);
  localparam logic [8:0]  L_MAX_CM   = 9'(MAX_CM);

  state_t      r_state, w_state_nx;
  logic [19:0] r_cnt, w_cnt_nx;
  logic [19:0] r_target, w_target_nx;
  logic        r_trig_meta, r_trig_s, r_trig_d;
  logic [2:0]  r_vld;
  logic        r_echo, r_ocupado, r_inv, r_done;
  logic        w_inv_nx, w_done_nx;
  logic        w_rise, w_fall;
  logic [8:0]  w_dist_eff;
  logic [19:0] w_width_calc;

  // r_vld marks when r_trig_d holds a real sample, so a trigger already high
  // at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_meta <= 1'b0;
      r_trig_s    <= 1'b0;
      r_trig_d    <= 1'b0;
      r_vld       <= 3'b000;
    end else begin
      r_trig_meta <= trigger;
      r_trig_s    <= r_trig_meta;
      r_trig_d    <= r_trig_s;
      r_vld       <= {r_vld[1:0], 1'b1};
    end
  end

  assign w_rise = r_vld[2] & r_trig_s & ~r_trig_d;
  assign w_fall = r_vld[2] & ~r_trig_s & r_trig_d;

  assign w_dist_eff   = (distancia_cm < L_MIN_CM) ? L_MIN_CM : distancia_cm;
  assign w_width_calc = (sin_objeto || (distancia_cm > L_MAX_CM)) ? L_TIMEOUT
                      : 20'(w_dist_eff) * L_CPC;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_target_nx = r_target;
    w_inv_nx    = 1'b0;
    w_done_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nx = S_TRIG;
          w_cnt_nx   = 20'd1;
        end
      end
      S_TRIG: begin
        if (w_fall) begin
          if (r_cnt >= L_TRIG_MIN) begin
            w_target_nx = w_width_calc;
            w_cnt_nx    = L_BURST_M1;
            w_state_nx  = S_BURST;
          end else begin
            w_inv_nx   = 1'b1;
            w_cnt_nx   = 20'd0;
            w_state_nx = S_IDLE;
          end
        end else if (r_trig_s && (r_cnt < L_TRIG_MIN)) begin
          w_cnt_nx = r_cnt + 20'd1;
        end
      end
      // BURST lasts BURST_CYC-1 cycles: the detection cycle counts as the first.
      S_BURST: begin
        if (r_cnt <= 20'd1) begin
          w_cnt_nx   = r_target;
          w_state_nx = S_ECHO;
        end else begin
          w_cnt_nx = r_cnt - 20'd1;
        end
      end
      S_ECHO: begin
        if (r_cnt <= 20'd1) begin
          w_cnt_nx   = L_HOLDOFF;
          w_done_nx  = 1'b1;
          w_state_nx = S_HOLD;
        end else begin
          w_cnt_nx = r_cnt - 20'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt <= 20'd1) begin
          w_cnt_nx   = 20'd0;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt - 20'd1;
        end
      end
      default: begin
        w_cnt_nx   = 20'd0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 20'd0;
      r_target  <= 20'd0;
      r_echo    <= 1'b0;
      r_ocupado <= 1'b0;
      r_inv     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_target  <= w_target_nx;
      r_echo    <= (w_state_nx == S_ECHO);
      r_ocupado <= (w_state_nx != S_IDLE);
      r_inv     <= w_inv_nx;
      r_done    <= w_done_nx;
    end
  end

  assign echo          = r_echo;
  assign ocupado       = r_ocupado;
  assign trig_invalido = r_inv;
  assign medida_hecha  = r_done;

endmodule

// File: doc/hcsr04_emulador.md
Name: hcsr04_emulador

Overview:
- Synthesizable model of the responder end of the HC-SR04 trigger/echo protocol.
- Receives the `trigger` pulse that our trigger controller generates, validates its width, waits the ultrasonic burst time, then drives `echo` high for a width proportional to a programmed distance.
- Used on-board and in benches as a loopback target for the echo measurement, BCD and 7-segment chain, with no physical sensor attached.

Parameters:
- TRIG_MIN_CYC, 250: minimum trigger high width in clk cycles (10 us at 25 MHz).
- BURST_CYC, 5000: delay from accepted trigger fall to echo rise (200 us, the 8x40 kHz burst).
- CYC_PER_CM, 1450: echo cycles per centimetre (58 us/cm at 25 MHz).
- MIN_CM, 2: lower clamp on distance.
- MAX_CM, 400: upper valid distance; larger values are treated as no-object.
- TIMEOUT_CYC, 950000: echo width when no object is present (38 ms).
- HOLDOFF_CYC, 25000: dead time after echo falls (1 ms).

Ports:
- clk  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous active-low reset.
- trigger  in  1  trigger from controller; asynchronous to this block.
- distancia_cm  in  9  simulated distance in cm; sampled once per measurement.
- sin_objeto  in  1  1 = simulate no echo return (timeout width).
- echo  out  1  echo pulse to the measurement logic.
- ocupado  out  1  high in any state other than IDLE.
- trig_invalido  out  1  one-cycle pulse: trigger fell before TRIG_MIN_CYC.
- medida_hecha  out  1  one-cycle pulse on the cycle echo deasserts.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - echo=0, ocupado=0, trig_invalido=0, medida_hecha=0.
  - FSM goes to IDLE; all counters and the synchronizer are cleared.
- trigger input:
  - Passes through a 2-FF synchronizer (trig_s), adding 2 cycles of latency.
  - All edge detection uses trig_s against its previous value.
- States: IDLE, TRIG, BURST, ECHO, HOLDOFF.
- IDLE:
  - On a rising edge of trig_s, go to TRIG and set width counter = 1.
  - If trig_s is already high on exit from reset, wait for the next rising edge.
- TRIG:
  - While trig_s=1, increment the width counter, saturating at TRIG_MIN_CYC.
  - On falling edge with counter >= TRIG_MIN_CYC:
    - Latch the distance: if sin_objeto=1 or distancia_cm>MAX_CM, target width = TIMEOUT_CYC; otherwise target width = max(distancia_cm, MIN_CM) * CYC_PER_CM.
    - Go to BURST.
  - On falling edge with counter < TRIG_MIN_CYC: pulse trig_invalido for 1 cycle and return to IDLE; echo stays 0.
- BURST:
  - Count BURST_CYC cycles, then go to ECHO.
  - echo rises exactly BURST_CYC cycles after the cycle in which the trig_s fall was detected.
- ECHO:
  - echo=1 for exactly the latched target width (20-bit counter; 400*1450=580000 and 950000 both fit).
  - The width comes either from a multiply at latch time or from nested cm/cycle counters; the observable width is identical either way.
  - On the final cycle: echo drops, medida_hecha pulses 1 cycle, go to HOLDOFF.
- HOLDOFF: count HOLDOFF_CYC cycles, then return to IDLE.
- Triggers during BURST, ECHO or HOLDOFF are ignored: no pulse, no restart, no trig_invalido.
- A trigger still high when HOLDOFF ends is not accepted; only a fresh rising edge in IDLE starts a measurement.
- distancia_cm and sin_objeto changes after the latch do not affect the measurement in progress.
- Reset mid-operation: echo drops asynchronously on rst_n fall; no medida_hecha pulse.
- Outputs are registered and glitch-free; exactly one echo pulse per accepted trigger.

Test Plan:
- Reset check: rst_n low, then release with trigger=0 -> echo=0, ocupado=0, no pulses for 1000 cycles.
- Nominal: distancia_cm=10, trigger high 250 cycles -> echo rises 5000 cycles after the detected fall, stays high exactly 14500 cycles; medida_hecha pulses once; ocupado falls 25000 cycles after echo.
- Short trigger: trigger high 249 cycles -> trig_invalido single-cycle pulse, echo never rises, FSM back in IDLE.
- Clamps:
  - distancia_cm=0 -> echo width 2900.
  - distancia_cm=401 -> echo width 950000.
  - sin_objeto=1, distancia_cm=50 -> echo width 950000.
- Ignored trigger: second 250-cycle trigger during ECHO -> echo width unchanged at 14500 (10 cm), no second echo, no trig_invalido.
- Reset mid-echo: rst_n low 7000 cycles into echo -> echo=0 immediately, no medida_hecha; after release a new 250-cycle trigger yields a normal pulse.
